// File: rtl/block_mem_responder_if.sv
// Block-transfer bus between a cache controller (master) and the backing block memory (slave).
`timescale 1ns/1ps
interface block_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface

// File: rtl/block_mem_responder.sv
// Fixed-latency 64 x 32-bit block memory that services one read or write per request.
// Define BLKMEM_RESET_CLEAR_EN to have reset also clear every memory word.
`timescale 1ns/1ps
module block_mem_responder #(
    parameter int unsigned LATENCY = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    block_mem_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q;
    logic [3:0]  count_q;
    logic        isWrite_q;
    logic [5:0]  addr_q;
    logic [31:0] writeData_q;
    logic [31:0] readData_q;
    logic [31:0] mem_q [64];
    logic        memWe;

    assign memWe = rst_ni && (state_q == BUSY) && (count_q == 4'd0) && isWrite_q;

    assign bus.mem_readdata = readData_q;
    assign bus.mem_busywait = ((state_q == IDLE) && (bus.mem_read || bus.mem_write))
                              || (state_q == BUSY);

    // A simultaneous read and write is latched as a write; the read is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            isWrite_q   <= 1'b0;
            addr_q      <= 6'd0;
            writeData_q <= 32'h0;
            readData_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        isWrite_q   <= bus.mem_write;
                        addr_q      <= bus.mem_address;
                        writeData_q <= bus.mem_writedata;
                        count_q     <= 4'(LATENCY - 1);
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_q == 4'd0) begin
                        if (!isWrite_q) begin
                            readData_q <= mem_q[addr_q];
                        end
                        state_q <= DONE;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BLKMEM_RESET_CLEAR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (memWe) begin
            mem_q[addr_q] <= writeData_q;
        end
    end
`else
    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[addr_q] <= writeData_q;
        end
    end
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed self-checking bench for block_mem_responder (LATENCY=5 main instance, LATENCY=1 corner instance).
`timescale 1ns/1ps
module tb_block_mem_responder;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    block_mem_responder_if bus ();
    block_mem_responder_if bus1 ();

    block_mem_responder #(.LATENCY(5)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    block_mem_responder #(.LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Presents one request at a negedge and holds it until busywait drops (the DONE cycle).
    // Optionally swaps address/data at a given cycle to show they are ignored once latched.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [5:0] addr,
                                 input logic [31:0] data, input int changeCycle,
                                 input logic [5:0] newAddr, input logic [31:0] newData,
                                 output int busyCycles, output logic [31:0] readData);
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.mem_address   = addr;
        bus.mem_writedata = data;
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == changeCycle) begin
                bus.mem_address   = newAddr;
                bus.mem_writedata = newData;
            end
            #1;
            if (!bus.mem_busywait) break;
            busyCycles++;
            @(negedge clk);
        end
        readData = bus.mem_readdata;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
    endtask

    int          busy;
    logic [31:0] rdata;

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
        bus.mem_address = 6'd0;  bus.mem_writedata = 32'h0;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
        bus1.mem_address = 6'd0; bus1.mem_writedata = 32'h0;

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("resetReadData", bus.mem_readdata, 32'h0);
        checkOutput("resetBusy", {31'b0, bus.mem_busywait}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 12 right after reset release, then read it back
        applyStimulus(1'b0, 1'b1, 6'd12, 32'hA1B2C3D4, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("wr12Busy", 32'(busy), 32'd6);
        checkOutput("wr12ReadDataKept", rdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 6'd12, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("rd12Busy", 32'(busy), 32'd6);
        checkOutput("rd12Data", rdata, 32'hA1B2C3D4);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        checkOutput("rd12Hold", bus.mem_readdata, 32'hA1B2C3D4);
        checkOutput("idleBusyLow", {31'b0, bus.mem_busywait}, 32'h0);

        // Write-back to 3 followed immediately by refill from 40
        applyStimulus(1'b0, 1'b1, 6'd40, 32'h40404040, -1, 6'd0, 32'h0, busy, rdata);
        applyStimulus(1'b0, 1'b1, 6'd3, 32'h03030303, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("wr3Busy", 32'(busy), 32'd6);
        applyStimulus(1'b1, 1'b0, 6'd40, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("b2bRd40Busy", 32'(busy), 32'd6);
        checkOutput("b2bRd40Data", rdata, 32'h40404040);
        applyStimulus(1'b1, 1'b0, 6'd3, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("rd3Data", rdata, 32'h03030303);

        // Address/data change during BUSY must not redirect the write
        applyStimulus(1'b0, 1'b1, 6'd9, 32'h09090909, -1, 6'd0, 32'h0, busy, rdata);
        applyStimulus(1'b0, 1'b1, 6'd7, 32'h00000055, 2, 6'd9, 32'h99999999, busy, rdata);
        checkOutput("wr7Busy", 32'(busy), 32'd6);
        checkOutput("wr7ReadDataKept", rdata, 32'h03030303);
        applyStimulus(1'b1, 1'b0, 6'd7, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("rd7Data", rdata, 32'h00000055);
        applyStimulus(1'b1, 1'b0, 6'd9, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("rd9Untouched", rdata, 32'h09090909);

        // Read and write together: write wins
        applyStimulus(1'b1, 1'b1, 6'd63, 32'hFFFF0000, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("rw63Busy", 32'(busy), 32'd6);
        checkOutput("rw63ReadDataKept", rdata, 32'h09090909);
        applyStimulus(1'b1, 1'b0, 6'd63, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("rd63Data", rdata, 32'hFFFF0000);

        // Reset in the middle of a write to 20
        applyStimulus(1'b0, 1'b1, 6'd20, 32'h00000011, -1, 6'd0, 32'h0, busy, rdata);
        bus.mem_write = 1'b1;
        bus.mem_address = 6'd20;
        bus.mem_writedata = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMidBusyReadData", bus.mem_readdata, 32'h0);
        bus.mem_write = 1'b0;
        #1;
        checkOutput("rstMidBusyIdle", {31'b0, bus.mem_busywait}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 6'd20, 32'h0, -1, 6'd0, 32'h0, busy, rdata);
        checkOutput("afterRstBusy", 32'(busy), 32'd6);
`ifdef BLKMEM_RESET_CLEAR_EN
        checkOutput("afterRstWord20", rdata, 32'h0);
`else
        checkOutput("afterRstWord20", rdata, 32'h00000011);
`endif

        // LATENCY=1 instance: read+write to 63 completes at the first edge after acceptance
        bus1.mem_read = 1'b1;
        bus1.mem_write = 1'b1;
        bus1.mem_address = 6'd63;
        bus1.mem_writedata = 32'hFFFF0000;
        #1;
        checkOutput("lat1ReqBusy", {31'b0, bus1.mem_busywait}, 32'h1);
        @(negedge clk);
        #1;
        checkOutput("lat1BusyCycle", {31'b0, bus1.mem_busywait}, 32'h1);
        @(negedge clk);
        #1;
        checkOutput("lat1DoneBusyLow", {31'b0, bus1.mem_busywait}, 32'h0);
        checkOutput("lat1ReadDataKept", bus1.mem_readdata, 32'h0);
        bus1.mem_read = 1'b0;
        bus1.mem_write = 1'b0;
        @(negedge clk);
        bus1.mem_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("lat1Rd63Data", bus1.mem_readdata, 32'hFFFF0000);
        bus1.mem_read = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_mem_responder.md
BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
- REQ-001: Parameter LATENCY, default 5: cycles from request acceptance to the completion edge; legal range 1..15.
- REQ-002: CLK  input  1  sole clock; all state changes on the rising edge.
- REQ-003: RESET  input  1  asynchronous, active-low reset.
- REQ-004: MEM_READ  input  1  block read request from the cache; held high until the transfer completes.
- REQ-005: MEM_WRITE  input  1  block write request from the cache; held high until the transfer completes.
- REQ-006: MEM_ADDRESS  input  6  block index, 64 blocks.
- REQ-007: MEM_WRITEDATA  input  32  block write data, 4 bytes; byte 0 is bits 7:0.
- REQ-008: MEM_READDATA  output  32  block read data; valid from the completion edge of a read.
- REQ-009: MEM_BUSYWAIT  output  1  high while a request is pending or in service.

Function
- REQ-010: Storage is 64 x 32-bit words, indexed by MEM_ADDRESS.
- REQ-011: The FSM has three states: IDLE, BUSY, DONE.
- REQ-012: IDLE: at a rising edge with MEM_READ or MEM_WRITE high, latch operation, address and write data; load counter with LATENCY-1; go to BUSY.
- REQ-013: MEM_BUSYWAIT is combinational: 1 in IDLE when (MEM_READ or MEM_WRITE), 1 in BUSY, 0 in DONE and in IDLE with no request.
- REQ-014: BUSY: decrement counter each edge. At the edge where counter equals 0, perform the latched access and go to DONE.
  - Total: the completion edge is LATENCY edges after the acceptance edge.
- REQ-015: Read completion: MEM_READDATA loads the addressed word at the completion edge and holds it until the next read completion.
- REQ-016: Write completion: the addressed word takes the latched data at the completion edge; MEM_READDATA is unchanged.
- REQ-017: DONE lasts exactly one cycle, then goes to IDLE unconditionally. Requests present during DONE are not accepted; the initiator drops or changes its request at the edge that ends DONE.
- REQ-018: Input changes during BUSY are ignored; the latched values are used.
- REQ-019: MEM_READ and MEM_WRITE both high at acceptance: the write is performed and the read is discarded.
- REQ-020: Back-to-back requests, e.g. write-back then refill, are accepted at the first edge after DONE; no extra idle cycle is required.

Reset
- REQ-021: RESET low asynchronously forces IDLE, counter=0, latched op/address/data=0, MEM_READDATA=32'h0. MEM_BUSYWAIT then follows REQ-013 for IDLE.
- REQ-022: Reset asserted mid-BUSY aborts the access: no memory word is modified and MEM_READDATA is 0.
- REQ-023: After RESET rises, the first request is accepted at the next rising edge.

Configuration
- REQ-024: With macro BLKMEM_RESET_CLEAR_EN defined, asserting RESET also clears all 64 words to 32'h0.
- REQ-025: Without BLKMEM_RESET_CLEAR_EN, memory contents are unaffected by reset and retain prior values; after power-up they are uninitialised (X in simulation).

Verification
- REQ-026: LATENCY=5, write 32'hA1B2C3D4 to block 6'd12 -> MEM_BUSYWAIT high for 6 cycles (IDLE request cycle plus 5 BUSY cycles), low in DONE; word 12 = A1B2C3D4; MEM_READDATA unchanged.
- REQ-027: Read block 12 after REQ-026 -> MEM_READDATA = 32'hA1B2C3D4 at the 5th edge after acceptance; value holds while idle.
- REQ-028: Write to block 3, then a read of block 40 presented in the cycle after DONE -> read accepted at that edge; no lost or duplicated access.
- REQ-029: Change MEM_ADDRESS from 7 to 9 two cycles into a write of 32'h55 -> only word 7 is updated.
- REQ-030: Assert RESET during BUSY of a write to block 20 (old value 32'h11) -> FSM in IDLE immediately; word 20 still 32'h11, or 32'h0 with BLKMEM_RESET_CLEAR_EN; MEM_READDATA = 0.
- REQ-031: MEM_READ and MEM_WRITE both high, data 32'hFFFF0000, block 63 -> word 63 = FFFF0000; MEM_READDATA unchanged; LATENCY=1 case completes at the first edge after acceptance.
